// File: rtl/trig_cascade_pkg.sv
// Shared definitions for the multi-channel trigger cascade: source-mode codes,
// channel FSM encoding and the per-channel source selection function.
package trig_cascade_pkg;

    localparam logic [1:0] SRC_LOCAL  = 2'd0;
    localparam logic [1:0] SRC_MASTER = 2'd1;
    localparam logic [1:0] SRC_OR     = 2'd2;
    localparam logic [1:0] SRC_AND    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_PULSE = 2'd2
    } chan_state_e;

    function automatic logic src_select(
        input logic [1:0] mode,
        input logic       loc,
        input logic       mst
    );
        logic sel;
        case (mode)
            SRC_LOCAL:  sel = loc;
            SRC_MASTER: sel = mst;
            SRC_OR:     sel = loc | mst;
            default:    sel = loc & mst;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/trig_cascade_chan.sv
// One trigger channel: registered source mux, rising-edge detect, delay/pulse
// FSM with a shared down-counter, and a sticky overrun flag.
module trig_cascade_chan
    import trig_cascade_pkg::*;
#(
    parameter int DLY_W = 16,
    parameter int PW_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [1:0]       i_mode,
    input  logic [DLY_W-1:0] i_delay,
    input  logic [PW_W-1:0]  i_width,
    input  logic             i_ovr_clr,
    input  logic             i_trig_loc,
    input  logic             i_trig_mst,
    output logic             o_trig,
    output logic             o_busy,
    output logic             o_ovr
);

    // One counter serves both phases, so it must hold the wider of the two.
    localparam int CNT_W = (DLY_W > PW_W) ? DLY_W : PW_W;

    logic             r_src_q;
    logic             r_src_d;
    logic             w_src_sel;
    logic             w_rise;
    chan_state_e      r_state;
    chan_state_e      w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [PW_W-1:0]  r_wid;
    logic [PW_W-1:0]  w_wid_next;
    logic [PW_W-1:0]  w_wid_eff;
    logic             r_trig;
    logic             r_busy;
    logic             r_ovr;
    logic             w_ovr_next;

    assign w_src_sel = src_select(i_mode, i_trig_loc, i_trig_mst);
    assign w_rise    = r_src_q & ~r_src_d;
    assign w_wid_eff = (i_width == '0) ? PW_W'(1) : i_width;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_wid_next   = r_wid;
        case (r_state)
            ST_IDLE: begin
                if (w_rise && i_en) begin
                    w_wid_next = w_wid_eff;
                    if (i_delay == '0) begin
                        w_state_next = ST_PULSE;
                        w_cnt_next   = CNT_W'(w_wid_eff) - CNT_W'(1);
                    end else begin
                        w_state_next = ST_DELAY;
                        w_cnt_next   = CNT_W'(i_delay) - CNT_W'(1);
                    end
                end
            end
            ST_DELAY: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_PULSE;
                    w_cnt_next   = CNT_W'(r_wid) - CNT_W'(1);
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            ST_PULSE: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
        // Disable overrides everything, including a pulse in flight.
        if (!i_en) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
        end
    end

    // A new edge while busy sets the flag; the set beats a same-cycle clear.
    always_comb begin
        w_ovr_next = r_ovr;
        if (w_rise && (r_state != ST_IDLE)) begin
            w_ovr_next = 1'b1;
        end else if (i_ovr_clr) begin
            w_ovr_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_src_q <= 1'b0;
            r_src_d <= 1'b0;
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_wid   <= '0;
            r_trig  <= 1'b0;
            r_busy  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_src_q <= w_src_sel;
            r_src_d <= r_src_q;
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_wid   <= w_wid_next;
            r_trig  <= (w_state_next == ST_PULSE);
            r_busy  <= (w_state_next != ST_IDLE);
            r_ovr   <= w_ovr_next;
        end
    end

    assign o_trig = r_trig;
    assign o_busy = r_busy;
    assign o_ovr  = r_ovr;

endmodule

// File: rtl/trigger_cascade_mc.sv
// Multi-channel trigger cascade top: slices the packed register vectors into
// N_CH independent channels. Define TRIG_CASCADE_SYNC_EN to add a 2-flop
// synchroniser on trigger_from_master (master paths gain 2 cycles of latency).
module trigger_cascade_mc
    import trig_cascade_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int DLY_W = 16,
    parameter int PW_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       reg_ch_en,
    input  logic [2*N_CH-1:0]     reg_src_mode,
    input  logic [DLY_W*N_CH-1:0] reg_delay,
    input  logic [PW_W*N_CH-1:0]  reg_width,
    input  logic [N_CH-1:0]       reg_ovr_clr,
    input  logic [N_CH-1:0]       trigger_i,
    input  logic [N_CH-1:0]       trigger_from_master,
    output logic [N_CH-1:0]       trigger_c,
    output logic [N_CH-1:0]       trigger_to_slave,
    output logic [N_CH-1:0]       busy,
    output logic [N_CH-1:0]       ovr_flag
);

    logic [N_CH-1:0] w_mst;
    logic [N_CH-1:0] w_trig;
    logic [N_CH-1:0] w_busy;
    logic [N_CH-1:0] w_ovr;

`ifdef TRIG_CASCADE_SYNC_EN
    logic [N_CH-1:0] r_mst_meta;
    logic [N_CH-1:0] r_mst_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mst_meta <= '0;
            r_mst_sync <= '0;
        end else begin
            r_mst_meta <= trigger_from_master;
            r_mst_sync <= r_mst_meta;
        end
    end

    assign w_mst = r_mst_sync;
`else
    assign w_mst = trigger_from_master;
`endif

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
        trig_cascade_chan #(
            .DLY_W (DLY_W),
            .PW_W  (PW_W)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .i_en       (reg_ch_en[gi]),
            .i_mode     (reg_src_mode[2*gi +: 2]),
            .i_delay    (reg_delay[DLY_W*gi +: DLY_W]),
            .i_width    (reg_width[PW_W*gi +: PW_W]),
            .i_ovr_clr  (reg_ovr_clr[gi]),
            .i_trig_loc (trigger_i[gi]),
            .i_trig_mst (w_mst[gi]),
            .o_trig     (w_trig[gi]),
            .o_busy     (w_busy[gi]),
            .o_ovr      (w_ovr[gi])
        );
    end

    assign trigger_c        = w_trig;
    assign trigger_to_slave = w_trig;
    assign busy             = w_busy;
    assign ovr_flag         = w_ovr;

endmodule
